// File: rtl/serial_word_rx.sv
// Framed serial-to-parallel receiver: start bit, WIDTH data bits LSB first, stop bit.
// Q holds the last correctly framed word; VALID/FERR are one-cycle strobes per frame.
//
// state  | meaning
// IDLE   | line idle, waiting for a low start bit
// DATA   | shifting in WIDTH data bits, LSB first
// STOP   | sampling the stop bit; high publishes the word, low flags a framing error
module serial_word_rx #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             SIN,
    output logic [WIDTH-1:0] Q,
    output logic             VALID,
    output logic             FERR,
    output logic             BUSY
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_STOP = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_q;
    logic             r_valid;
    logic             r_ferr;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state <= S_IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_q     <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!SIN) begin
                        r_state <= S_DATA;
                        r_cnt   <= '0;
                    end
                end
                S_DATA: begin
                    // Zeros here are data; no start-bit hunting mid-frame.
                    r_sr  <= {SIN, r_sr[WIDTH-1:1]};
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST_BIT) begin
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    // Always back to IDLE: a low stop bit is never taken as a new start.
                    r_state <= S_IDLE;
                    if (SIN) begin
                        r_q     <= r_sr;
                        r_valid <= 1'b1;
                    end else begin
                        r_ferr  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Q     = r_q;
    assign VALID = r_valid;
    assign FERR  = r_ferr;
    assign BUSY  = (r_state == S_DATA) || (r_state == S_STOP);

endmodule

// File: tb/tb_serial_word_rx.sv
// Bench for serial_word_rx: frame table plus scoreboard for WIDTH=4, and a
// direct WIDTH=8 frame check on a second instance.
module tb_serial_word_rx;

    logic       CLK;
    logic       RESETN;
    logic       SIN;
    logic [3:0] Q;
    logic       VALID, FERR, BUSY;

    logic       SIN8;
    logic [7:0] Q8;
    logic       VALID8, FERR8, BUSY8;

    int n_pass  = 0;
    int n_total = 0;

    serial_word_rx #(.WIDTH(4)) dut4 (
        .CLK(CLK), .RESETN(RESETN), .SIN(SIN),
        .Q(Q), .VALID(VALID), .FERR(FERR), .BUSY(BUSY)
    );

    serial_word_rx #(.WIDTH(8)) dut8 (
        .CLK(CLK), .RESETN(RESETN), .SIN(SIN8),
        .Q(Q8), .VALID(VALID8), .FERR(FERR8), .BUSY(BUSY8)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    typedef struct packed {
        logic       v;
        logic [3:0] q;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [3:0] data;
        logic       stop;
        int         gap;
        logic       exp_v;
        logic [3:0] exp_q;
    } vec_t;

    vec_t tbl[11];

    // Output monitor: every strobe must match the oldest pending expectation,
    // and Q may only move on a VALID cycle.
    logic [3:0] prev_q = 4'h0;
    always @(negedge CLK) begin
        if (RESETN) begin
            if (VALID || FERR) begin
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                chk("strobe_excl", 32'(VALID & FERR), 32'd0);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_kind", 32'(VALID), 32'(e.v));
                    chk("sb_q", 32'(Q), 32'(e.q));
                end
            end
            if (!VALID) chk("q_hold", 32'(Q), 32'(prev_q));
        end
        prev_q = Q;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        SIN = 1'b1;
        repeat (n) tick();
    endtask

    task automatic send4(input logic [3:0] data, input logic stop,
                         input logic exp_v, input logic [3:0] exp_q);
        exp_t e;
        e.v = exp_v;
        e.q = exp_q;
        sb.push_back(e);
        SIN = 1'b0;
        tick();
        chk("busy_start", 32'(BUSY), 32'd1);
        for (int i = 0; i < 4; i++) begin
            SIN = data[i];
            tick();
            chk("busy_data", 32'(BUSY), 32'd1);
            chk("no_early_strobe", 32'(VALID | FERR), 32'd0);
        end
        SIN = stop;
        tick();
        chk("stop_valid", 32'(VALID), 32'(exp_v));
        chk("stop_ferr", 32'(FERR), 32'(!exp_v));
        chk("stop_q", 32'(Q), 32'(exp_q));
        chk("busy_after_stop", 32'(BUSY), 32'd0);
        SIN = 1'b1;
    endtask

    initial begin
        int busy_seen;
        int pulse_seen;
        logic [7:0] w8;

        tbl[0]  = '{4'b1001, 1'b1, 2, 1'b1, 4'b1001};
        tbl[1]  = '{4'b1101, 1'b1, 0, 1'b1, 4'b1101};
        tbl[2]  = '{4'b1001, 1'b1, 1, 1'b1, 4'b1001};
        tbl[3]  = '{4'b0110, 1'b0, 0, 1'b0, 4'b1001};
        tbl[4]  = '{4'b0000, 1'b1, 3, 1'b1, 4'b0000};
        tbl[5]  = '{4'b0000, 1'b0, 0, 1'b0, 4'b0000};
        tbl[6]  = '{4'b0000, 1'b0, 0, 1'b0, 4'b0000};
        tbl[7]  = '{4'b1111, 1'b1, 0, 1'b1, 4'b1111};
        tbl[8]  = '{4'b0101, 1'b1, 2, 1'b1, 4'b0101};
        tbl[9]  = '{4'b1010, 1'b0, 0, 1'b0, 4'b0101};
        tbl[10] = '{4'b0011, 1'b1, 1, 1'b1, 4'b0011};

        RESETN = 1'b0;
        SIN    = 1'b1;
        SIN8   = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_q", 32'(Q), 32'd0);
        chk("rst_valid", 32'(VALID), 32'd0);
        chk("rst_ferr", 32'(FERR), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_q8", 32'(Q8), 32'd0);
        RESETN = 1'b1;

        // Idle line: nothing may happen.
        busy_seen  = 0;
        pulse_seen = 0;
        for (int i = 0; i < 20; i++) begin
            SIN = 1'b1;
            tick();
            if (BUSY) busy_seen++;
            if (VALID || FERR) pulse_seen++;
        end
        chk("idle_busy", 32'(busy_seen), 32'd0);
        chk("idle_pulses", 32'(pulse_seen), 32'd0);

        foreach (tbl[k]) begin
            idle(tbl[k].gap);
            send4(tbl[k].data, tbl[k].stop, tbl[k].exp_v, tbl[k].exp_q);
        end
        idle(1);
        chk("ferr_no_restart", 32'(BUSY), 32'd0);

        // Reset mid-frame after two data bits of 4'b1101.
        SIN = 1'b0; tick();
        SIN = 1'b1; tick();
        SIN = 1'b0; tick();
        #2;
        RESETN = 1'b0;
        #1;
        chk("async_rst_q", 32'(Q), 32'd0);
        chk("async_rst_busy", 32'(BUSY), 32'd0);
        chk("async_rst_valid", 32'(VALID), 32'd0);
        SIN = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RESETN = 1'b1;
        idle(2);
        chk("post_rst_idle", 32'(BUSY), 32'd0);
        send4(4'b1101, 1'b1, 1'b1, 4'b1101);
        idle(2);

        // WIDTH=8: start edge t, VALID visible after edge t+9.
        w8 = 8'hA5;
        SIN8 = 1'b0;
        tick();
        chk("w8_busy", 32'(BUSY8), 32'd1);
        for (int i = 0; i < 8; i++) begin
            SIN8 = w8[i];
            tick();
            chk("w8_no_early", 32'(VALID8 | FERR8), 32'd0);
        end
        SIN8 = 1'b1;
        tick();
        chk("w8_valid", 32'(VALID8), 32'd1);
        chk("w8_q", 32'(Q8), 32'hA5);
        chk("w8_ferr", 32'(FERR8), 32'd0);
        tick();
        chk("w8_valid_one_cycle", 32'(VALID8), 32'd0);
        chk("w8_q_held", 32'(Q8), 32'hA5);

        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
